// File: rtl/instr_mem_loadable_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable_if
//   Bundles the program-load port and the fetch port of the loadable
//   instruction memory.
//
//   Load port  : load_start, load_valid, load_data, load_done  (to memory)
//                load_ready, load_count                        (from memory)
//   Fetch port : fetch_en, read_address                        (to memory)
//                instruction, instr_valid, fetch_fault, running (from memory)
//
//   Handshake: a load word transfers on a rising clk edge where both
//   load_valid and load_ready are high; load_valid may be raised without
//   waiting for load_ready, and load_ready never depends on load_valid.
//
//   master : the CPU / loader side.  slave : the memory.
// ---------------------------------------------------------------------------
interface instr_mem_loadable_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 7
);
   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  load_done;
   logic [CNT_WIDTH-1:0]  load_count;
   logic                  fetch_en;
   logic [ADDR_WIDTH-1:0] read_address;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  instr_valid;
   logic                  fetch_fault;
   logic                  running;

   modport master (
      output load_start, load_valid, load_data, load_done, fetch_en, read_address,
      input  load_ready, load_count, instruction, instr_valid, fetch_fault, running
   );

   modport slave (
      input  load_start, load_valid, load_data, load_done, fetch_en, read_address,
      output load_ready, load_count, instruction, instr_valid, fetch_fault, running
   );
endinterface

// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
//   Loadable instruction memory for the pipelined MIPS fetch stage. A program
//   is streamed in over the load port (EMPTY/LOAD), then fetches are served
//   with a registered one-cycle read (RUN). Misaligned fetches and fetches at
//   or beyond the number of loaded words return NOP_WORD and set fetch_fault.
//
//   Ports:
//     clk       : system clock, rising edge
//     reset     : asynchronous, active-high
//     bus       : instr_mem_loadable_if.slave (load + fetch ports)
//     state_dbg : current FSM state (0 EMPTY, 1 LOAD, 2 RUN)
// ---------------------------------------------------------------------------
module instr_mem_loadable #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 64,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000,
   parameter int                    CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_mem_loadable_if.slave  bus,
   output logic [1:0]           state_dbg
);

   localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  load_count_q, load_count_d;
   logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
   logic                  instr_valid_q, instr_valid_d;
   logic                  fetch_fault_q, fetch_fault_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  load_ready;
   logic                  load_accept;
   logic [ADDR_WIDTH-1:0] word_index;
   logic                  fetch_ok;

   // load_ready deliberately ignores load_valid so the handshake has no
   // combinational loop back to the loader.
   assign load_ready  = (state_q == ST_LOAD) &&
                        (load_count_q < CNT_WIDTH'(DEPTH)) &&
                        !bus.load_start;
   assign load_accept = load_ready && bus.load_valid;

   // Full-width index compare: any upper address bit set lands beyond
   // load_count and so counts as out of range.
   assign word_index = bus.read_address >> 2;
   assign fetch_ok   = (bus.read_address[1:0] == 2'b00) &&
                       (word_index < ADDR_WIDTH'(load_count_q));

   always_comb begin
      state_d       = state_q;
      load_count_d  = load_count_q;
      instruction_d = NOP_WORD;
      instr_valid_d = 1'b0;
      fetch_fault_d = 1'b0;

      if (state_q == ST_RUN) begin
         if (bus.fetch_en) begin
            instr_valid_d = 1'b1;
            if (fetch_ok) begin
               instruction_d = mem[word_index[IDX_WIDTH-1:0]];
            end else begin
               fetch_fault_d = 1'b1;
            end
         end else begin
            // Stall: hold the last fetch result.
            instruction_d = instruction_q;
            instr_valid_d = instr_valid_q;
            fetch_fault_d = fetch_fault_q;
         end
      end

      if (load_accept) begin
         load_count_d = load_count_q + 1'b1;
      end

      // load_start beats load_done; a word accepted alongside load_done is
      // already included in load_count_d when deciding RUN vs EMPTY.
      if (bus.load_start) begin
         state_d      = ST_LOAD;
         load_count_d = '0;
      end else if ((state_q == ST_LOAD) && bus.load_done) begin
         state_d = (load_count_d != '0) ? ST_RUN : ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_EMPTY;
         load_count_q  <= '0;
         instruction_q <= NOP_WORD;
         instr_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         load_count_q  <= load_count_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   // Storage is not reset; contents become meaningful only once counted.
   always_ff @(posedge clk) begin
      if (load_accept) begin
         mem[load_count_q[IDX_WIDTH-1:0]] <= bus.load_data;
      end
   end

   assign bus.load_ready  = load_ready;
   assign bus.load_count  = load_count_q;
   assign bus.instruction = instruction_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.fetch_fault = fetch_fault_q;
   assign bus.running     = (state_q == ST_RUN);
   assign state_dbg       = state_q;

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the pipelined MIPS CPU, replacing the fixed-program combinational ROM in the fetch stage. The program is streamed in over a valid/ready load port, and fetches are served with a registered one-cycle read, with stall (hold) support. Misaligned and out-of-range fetches return a NOP and raise a fault flag.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- DEPTH, 64, memory depth in words (≥2)
- ADDR_WIDTH, 32, byte-address width of read_address
- NOP_WORD, 32'h0000_0000, word returned on fault or when not running
- CNT_WIDTH, $clog2(DEPTH+1), width of load_count

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  pulse; enter LOAD and clear the load pointer
- load_valid  in  1  load_data is valid
- load_data  in  DATA_WIDTH  program word to write
- load_ready  out  1  memory accepts a word this cycle
- load_done  in  1  pulse; end loading
- load_count  out  CNT_WIDTH  words loaded so far
- fetch_en  in  1  1 = fetch, 0 = stall (hold outputs)
- read_address  in  ADDR_WIDTH  byte address (PC)
- instruction  out  DATA_WIDTH  registered fetched word
- instr_valid  out  1  instruction holds a real fetch result
- fetch_fault  out  1  last fetch was misaligned or out of range
- running  out  1  state == RUN

## Operation
- States: EMPTY (after reset), LOAD, RUN.
- Reset values: state = EMPTY, load_count = 0, instruction = NOP_WORD, instr_valid = 0, fetch_fault = 0, load_ready = 0, running = 0. The memory array is not reset.
- Transitions:
  - load_start in any state goes to LOAD and sets load_count = 0. This includes restarting while already in LOAD.
  - load_done in LOAD goes to RUN if the post-edge load_count > 0, otherwise to EMPTY.
  - load_done outside LOAD is ignored.
  - load_start and load_done in the same cycle: load_start wins.
- LOAD:
  - load_ready = 1 (combinational) iff state == LOAD, load_count < DEPTH, and load_start is low.
  - When load_valid & load_ready: mem[load_count] <= load_data and load_count increments.
  - At load_count == DEPTH, load_ready = 0 and further load_valid is ignored. No wrap.
  - A word accepted in the same cycle as load_done is written and counted before entering RUN.
- RUN, fetch_en = 1 (word index = read_address >> 2):
  - Aligned (read_address[1:0] == 0) and index < load_count: instruction <= mem[index], fetch_fault <= 0.
  - Otherwise: instruction <= NOP_WORD, fetch_fault <= 1.
  - instr_valid <= 1 in both cases.
  - Range is bounded by load_count, not DEPTH. Upper address bits beyond the index width count as out of range.
- RUN, fetch_en = 0: instruction, instr_valid and fetch_fault hold their values.
- EMPTY or LOAD: every cycle, instruction <= NOP_WORD, instr_valid <= 0, fetch_fault <= 0. fetch_en is ignored.
- Leaving RUN through load_start drops instr_valid on the next edge.

## Timing
- Fetch latency is 1 cycle: an address presented at edge N appears on instruction after edge N.
- The first valid fetch can be issued in the cycle after the load_done edge. Its result appears one edge later.
- Load throughput is 1 word per cycle. load_count updates on the accepting edge.
- reset asserted mid-load or mid-run forces all reset values immediately, without waiting for clk. Loaded contents are then unusable: state is EMPTY and load_count = 0.
- No combinational path from read_address to instruction. load_ready depends only on state, load_count and load_start.

## Test plan
- Reset then idle: instruction = 0, instr_valid = 0, load_ready = 0, running = 0 for 5 cycles, even with fetch_en = 1.
- Load 30 words (word i = 32'h2008_0000 + i) back-to-back, then pulse load_done. load_count = 30, running = 1. Fetch addresses 0, 4, 116 in consecutive cycles. Outputs are 32'h2008_0000, 32'h2008_0001, 32'h2008_001D, each one cycle late, with fetch_fault = 0.
- Faults after that load:
  - Fetch address 6 gives NOP with fetch_fault = 1.
  - Fetch address 120 (index 30 ≥ load_count) gives NOP with fault.
  - Fetch address 0 after that clears fetch_fault.
- Stall: fetch address 8, then drop fetch_en for 3 cycles while read_address changes. instruction stays at word 2 and instr_valid stays 1.
- Full and restart:
  - Offer DEPTH + 3 words. Exactly DEPTH are accepted, load_ready falls at count = DEPTH, and load_count = 64.
  - Assert load_start and load_done together: state stays LOAD with count 0.
  - Then assert load_done with no words: state = EMPTY.
- Async reset mid-RUN, asserted between clock edges: outputs go to reset values immediately. A fetch after release returns NOP with instr_valid = 0.
